// File: rtl/uart_tx_arbiter.sv
// Purpose: round-robin arbiter/sequencer sharing one uart_tx byte transmitter among NUM_REQ byte streams, with per-frame grant lock.
// Latency: req_valid in cycle t gives registered grant/tx_start/req_ready in cycle t+1; one idle cycle minimum between owners.
// Backpressure: tx_start is held with stable tx_data until tx_ready accepts it; requesters hold their byte until req_ready pulses.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int MAX_BURST    = 16,
    parameter int HOLD_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_start,
    input  logic                 tx_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t          state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   owner;
    logic            last_flag;
    logic            drain_first;
    logic [7:0]      byte_cnt;
    logic [7:0]      hold_cnt;

    logic [7:0]      req_byte [NUM_REQ];
    logic            pick_found;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   ptr_after_owner;
    logic            burst_done;
    logic            owner_valid;
    logic [7:0]      byte_cnt_inc;
    logic [7:0]      hold_cnt_inc;
    logic            drain_eval;
    logic            do_release;
    logic            do_latch;
    logic            go_hold;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Split the flat data bus into one byte per requester.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_byte[i] = req_data[8*i +: 8];
        end
    end

    // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
    // Scanning from the far end lets the nearest candidate overwrite the rest.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            logic [IW-1:0] cand;
            cand = IW'((int'(rr_ptr) + k) % NUM_REQ);
            if (req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Lock-phase decisions for the current owner; the first DRAIN cycle is
    // skipped because the transmitter still shows ready right after accepting.
    always_comb begin
        ptr_after_owner = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
        burst_done      = (byte_cnt == 8'(MAX_BURST));
        owner_valid     = req_valid[owner];
        byte_cnt_inc    = burst_done ? byte_cnt : byte_cnt + 8'd1;
        hold_cnt_inc    = hold_cnt + 8'd1;
        drain_eval      = (state == S_DRAIN) && !drain_first && tx_ready;
        do_release      = 1'b0;
        do_latch        = 1'b0;
        go_hold         = 1'b0;
        if (drain_eval) begin
            if (last_flag || burst_done) begin
                do_release = 1'b1;
            end else if (owner_valid) begin
                do_latch = 1'b1;
            end else begin
                go_hold = 1'b1;
            end
        end else if (state == S_HOLD) begin
            if (owner_valid) begin
                do_latch = 1'b1;
            end else if (hold_cnt_inc == 8'(HOLD_TIMEOUT)) begin
                do_release = 1'b1;
            end
        end
    end

    // Sequencer: owns every registered output, the lock state and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            rr_ptr      <= '0;
            owner       <= '0;
            last_flag   <= 1'b0;
            drain_first <= 1'b0;
            byte_cnt    <= 8'd0;
            hold_cnt    <= 8'd0;
            req_ready   <= '0;
            tx_data     <= 8'h00;
            tx_start    <= 1'b0;
            grant       <= '0;
            busy        <= 1'b0;
        end else begin
            req_ready <= '0;
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        grant     <= onehot(pick_idx);
                        owner     <= pick_idx;
                        req_ready <= onehot(pick_idx);
                        tx_data   <= req_byte[pick_idx];
                        last_flag <= req_last[pick_idx];
                        tx_start  <= 1'b1;
                        byte_cnt  <= 8'd1;
                        busy      <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (tx_start && tx_ready) begin
                        tx_start    <= 1'b0;
                        drain_first <= 1'b1;
                        state       <= S_DRAIN;
                    end
                end
                S_DRAIN, S_HOLD: begin
                    if (state == S_DRAIN && drain_first) begin
                        drain_first <= 1'b0;
                    end
                    if (do_release) begin
                        grant  <= '0;
                        busy   <= 1'b0;
                        rr_ptr <= ptr_after_owner;
                        state  <= S_IDLE;
                    end else if (do_latch) begin
                        req_ready <= onehot(owner);
                        tx_data   <= req_byte[owner];
                        last_flag <= req_last[owner];
                        tx_start  <= 1'b1;
                        byte_cnt  <= byte_cnt_inc;
                        state     <= S_ISSUE;
                    end else if (go_hold) begin
                        hold_cnt <= 8'd0;
                        state    <= S_HOLD;
                    end else if (state == S_HOLD) begin
                        hold_cnt <= hold_cnt_inc;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Purpose: self-checking bench for uart_tx_arbiter with a byte-level transmitter model and queued requesters.
// Latency: expects grant/tx_start/req_ready one cycle after valid; transmitter busy TXB cycles after accepting.
// Backpressure: transmitter model holds ready high one cycle after accept, then low; a stall flag forces ready low.
module tb_uart_tx_arbiter;

    localparam int NR  = 4;
    localparam int MB  = 4;
    localparam int HT  = 10;
    localparam int TXB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] req_valid;
    logic [8*NR-1:0] req_data;
    logic [NR-1:0] req_last;
    logic [NR-1:0] req_ready;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic          tx_ready;
    logic [NR-1:0] grant;
    logic          busy;

    logic model_rdy;
    logic stall;
    assign tx_ready = model_rdy & ~stall;

    typedef struct {
        int         idx;
        logic [7:0] data;
    } sb_t;
    sb_t sb[$];

    logic [8:0] rq [NR][$];
    bit         use_model;
    int         acc_cnt [NR];
    int         n_checks;
    int         n_fail;

    typedef struct {
        logic [3:0] mask;
        logic [7:0] base;
        int         exp_idx;
        logic [7:0] exp_data;
    } vec_t;
    vec_t vecs [8];

    uart_tx_arbiter #(.NUM_REQ(NR), .MAX_BURST(MB), .HOLD_TIMEOUT(HT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_ready  (tx_ready),
        .grant     (grant),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    function automatic bit queues_empty();
        for (int i = 0; i < NR; i++) begin
            if (rq[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic wait_idle(input string name, input int lim);
        int c;
        c = 0;
        while ((busy || sb.size() != 0 || !queues_empty()) && c < lim) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (c >= lim) bound_fail(name);
    endtask

    task automatic push_sb(input int idx, input logic [7:0] d);
        sb_t e;
        e.idx  = idx;
        e.data = d;
        sb.push_back(e);
    endtask

    // Requesters: present queue head, advance when req_ready pulses.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (use_model) begin
                for (int i = 0; i < NR; i++) begin
                    if (req_ready[i] && rq[i].size() > 0) void'(rq[i].pop_front());
                    if (rq[i].size() > 0) begin
                        req_valid[i]        = 1'b1;
                        req_data[8*i +: 8]  = rq[i][0][7:0];
                        req_last[i]         = rq[i][0][8];
                    end else begin
                        req_valid[i]        = 1'b0;
                        req_data[8*i +: 8]  = 8'h00;
                        req_last[i]         = 1'b0;
                    end
                end
            end
        end
    end

    // Transmitter: accept on start&&ready, compare against scoreboard, then go busy.
    initial begin
        logic [7:0]    d;
        logic [NR-1:0] g;
        sb_t           e;
        model_rdy = 1'b1;
        forever begin
            @(negedge clk);
            if (tx_start && tx_ready) begin
                d = tx_data;
                g = grant;
                if (sb.size() == 0) begin
                    bound_fail("unexpected_tx_byte");
                end else begin
                    e = sb.pop_front();
                    check("tx_byte", 32'(d), 32'(e.data));
                    check("tx_owner", 32'(g), 32'(1 << e.idx));
                end
                for (int i = 0; i < NR; i++) if (g[i]) acc_cnt[i]++;
                @(posedge clk);
                @(posedge clk);
                #1 model_rdy = 1'b0;
                repeat (TXB) @(posedge clk);
                #1 model_rdy = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int c;
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        stall     = 1'b0;
        use_model = 1'b0;
        for (int i = 0; i < NR; i++) acc_cnt[i] = 0;

        vecs[0] = '{4'b0100, 8'hA3, 2, 8'hA5};
        vecs[1] = '{4'b0011, 8'h10, 0, 8'h10};
        vecs[2] = '{4'b0011, 8'h20, 1, 8'h21};
        vecs[3] = '{4'b1001, 8'h30, 3, 8'h33};
        vecs[4] = '{4'b1111, 8'h40, 0, 8'h40};
        vecs[5] = '{4'b1000, 8'h50, 3, 8'h53};
        vecs[6] = '{4'b0110, 8'h60, 1, 8'h61};
        vecs[7] = '{4'b0001, 8'h70, 0, 8'h70};

        repeat (3) @(posedge clk);
        #1;
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_tx_start", 32'(tx_start), 32'h0);
        check("rst_tx_data", 32'(tx_data), 32'h0);
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;

        // Single-shot arbitration vectors, each byte is last of its frame.
        for (int v = 0; v < 8; v++) begin
            @(posedge clk);
            #1;
            req_valid = vecs[v].mask;
            for (int j = 0; j < NR; j++) req_data[8*j +: 8] = vecs[v].base + 8'(j);
            req_last = 4'hF;
            push_sb(vecs[v].exp_idx, vecs[v].exp_data);
            @(posedge clk);
            #1;
            check("vec_grant", 32'(grant), 32'(1 << vecs[v].exp_idx));
            check("vec_tx_start", 32'(tx_start), 32'h1);
            check("vec_tx_data", 32'(tx_data), 32'(vecs[v].exp_data));
            check("vec_req_ready", 32'(req_ready), 32'(1 << vecs[v].exp_idx));
            check("vec_busy", 32'(busy), 32'h1);
            req_valid = '0;
            @(posedge clk);
            #1;
            check("vec_tx_start_drop", 32'(tx_start), 32'h0);
            check("vec_req_ready_pulse", 32'(req_ready), 32'h0);
            wait_idle("vec_idle", 200);
            check("vec_grant_released", 32'(grant), 32'h0);
        end

        // Fairness: all requesters continuously valid, pointer starts at 1.
        @(posedge clk);
        #1;
        use_model = 1'b1;
        for (int i = 0; i < NR; i++) acc_cnt[i] = 0;
        for (int r = 0; r < NR; r++) begin
            rq[r].push_back({1'b1, 8'(16*r)});
            rq[r].push_back({1'b1, 8'(16*r + 1)});
        end
        for (int k = 0; k < 2; k++) begin
            push_sb(1, 8'(16*1 + k));
            push_sb(2, 8'(16*2 + k));
            push_sb(3, 8'(16*3 + k));
            push_sb(0, 8'(16*0 + k));
        end
        wait_idle("fair_idle", 2000);
        for (int i = 0; i < NR; i++) check("fair_share", 32'(acc_cnt[i]), 32'd2);

        // Lock: req 1 frame of three bytes goes out before req 0.
        @(posedge clk);
        #1;
        rq[1].push_back(9'h011);
        rq[1].push_back(9'h022);
        rq[1].push_back(9'h133);
        rq[0].push_back(9'h144);
        push_sb(1, 8'h11);
        push_sb(1, 8'h22);
        push_sb(1, 8'h33);
        push_sb(0, 8'h44);
        wait_idle("lock_idle", 1000);

        // Burst cap: req 3 cut after MB bytes, req 0 served, req 3 resumes.
        @(posedge clk);
        #1;
        for (int k = 0; k < 6; k++) rq[3].push_back({(k == 5) ? 1'b1 : 1'b0, 8'(8'hA0 + k)});
        rq[0].push_back(9'h1B0);
        for (int k = 0; k < 4; k++) push_sb(3, 8'(8'hA0 + k));
        push_sb(0, 8'hB0);
        push_sb(3, 8'hA4);
        push_sb(3, 8'hA5);
        wait_idle("burst_idle", 2000);

        // Hold timeout: req 0 goes quiet mid-frame, req 1 waits behind the lock.
        @(posedge clk);
        #1;
        rq[0].push_back(9'h0C0);
        rq[1].push_back(9'h1D1);
        push_sb(0, 8'hC0);
        push_sb(1, 8'hD1);
        c = 0;
        while (tx_ready && c < 200) begin
            @(negedge clk);
            c++;
        end
        if (c >= 200) bound_fail("hold_ready_fall");
        c = 0;
        while (!tx_ready && c < 200) begin
            @(negedge clk);
            c++;
        end
        if (c >= 200) bound_fail("hold_ready_rise");
        cnt = 0;
        while (grant == 4'b0001 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check("hold_cycles", 32'(cnt), 32'(HT + 1));
        wait_idle("hold_idle", 500);

        // Stalled transmitter keeps the start request steady; reset abandons it.
        @(posedge clk);
        #1;
        stall = 1'b1;
        rq[2].push_back(9'h1E7);
        c = 0;
        while (!tx_start && c < 50) begin
            @(negedge clk);
            c++;
        end
        if (c >= 50) bound_fail("stall_start");
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("stall_tx_start", 32'(tx_start), 32'h1);
            check("stall_tx_data", 32'(tx_data), 32'hE7);
            check("stall_grant", 32'(grant), 32'b0100);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_grant", 32'(grant), 32'h0);
        check("mid_rst_tx_start", 32'(tx_start), 32'h0);
        check("mid_rst_tx_data", 32'(tx_data), 32'h0);
        check("mid_rst_req_ready", 32'(req_ready), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        rst   = 1'b0;
        stall = 1'b0;

        // Pointer restarts at 0 after reset: req 1 wins over req 3.
        @(posedge clk);
        #1;
        rq[1].push_back(9'h15A);
        rq[3].push_back(9'h13C);
        push_sb(1, 8'h5A);
        push_sb(3, 8'h3C);
        wait_idle("post_rst_idle", 500);
        check("sb_drained", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
